// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event classifier: FSM state encoding and default timing.
package key_evt_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] PRESS1    = 3'd1;
    localparam logic [STATE_W-1:0] WAIT2     = 3'd2;
    localparam logic [STATE_W-1:0] PRESS2    = 3'd3;
    localparam logic [STATE_W-1:0] LONG_HOLD = 3'd4;

    localparam int unsigned LONG_CYC_DEF   = 200000;
    localparam int unsigned DBL_CYC_DEF    = 100000;
    localparam int unsigned REPEAT_CYC_DEF = 50000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_evt_timer.sv
// Clear/enable cycle counter with a terminal-count flag against a runtime limit.
module key_evt_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = enable && (cnt == limit);

endmodule

// File: rtl/key_event_classifier.sv
// Classifies press/release pulses into short press, double click, long press and auto-repeat.
module key_event_classifier
    import key_evt_pkg::*;
#(
    parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
    parameter int unsigned DBL_CYC    = DBL_CYC_DEF,
    parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in_press_pulse,
    input  logic in_release_pulse,
    output logic out_short_press,
    output logic out_double_click,
    output logic out_long_press,
    output logic out_repeat,
    output logic out_key_held
);

    localparam int unsigned CNT_W = $clog2(max3(LONG_CYC, DBL_CYC, REPEAT_CYC));

    // Terminal values are one less than the period, so they always fit in CNT_W bits.
    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LIM  = CNT_W'(REPEAT_CYC - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic               press_v, release_v;
    logic               restart;
    logic               timer_clear, timer_en, timer_done;
    logic [CNT_W-1:0]   timer_limit;
    logic               short_d, dbl_d, long_d, rpt_d, held_d;

    // Simultaneous press and release carry no usable ordering, so both are dropped.
    assign press_v   = in_press_pulse && !in_release_pulse;
    assign release_v = in_release_pulse && !in_press_pulse;

    // PRESS2 has no timeout, so the counter is frozen there as well as in IDLE.
    always_comb begin
        timer_limit = '0;
        timer_en    = 1'b0;
        case (state_q)
            PRESS1: begin
                timer_limit = LONG_LIM;
                timer_en    = 1'b1;
            end
            WAIT2: begin
                timer_limit = DBL_LIM;
                timer_en    = 1'b1;
            end
            LONG_HOLD: begin
                timer_limit = RPT_LIM;
                timer_en    = 1'b1;
            end
            default: begin
                timer_limit = '0;
                timer_en    = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        short_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_v) state_d = PRESS1;
            end
            PRESS1: begin
                if (release_v) begin
                    state_d = WAIT2;
                end else if (timer_done) begin
                    state_d = LONG_HOLD;
                    long_d  = 1'b1;
                end
            end
            WAIT2: begin
                if (press_v) begin
                    state_d = PRESS2;
                end else if (timer_done) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (release_v) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end
            end
            LONG_HOLD: begin
                if (release_v) begin
                    state_d = IDLE;
                end else if (timer_done) begin
                    rpt_d   = 1'b1;
                    restart = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign timer_clear = (state_d != state_q) || restart;
    assign held_d      = (state_d == PRESS1) || (state_d == PRESS2) || (state_d == LONG_HOLD);

    key_evt_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .limit  (timer_limit),
        .done   (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            out_short_press  <= 1'b0;
            out_double_click <= 1'b0;
            out_long_press   <= 1'b0;
            out_repeat       <= 1'b0;
            out_key_held     <= 1'b0;
        end else begin
            state_q          <= state_d;
            out_short_press  <= short_d;
            out_double_click <= dbl_d;
            out_long_press   <= long_d;
            out_repeat       <= rpt_d;
            out_key_held     <= held_d;
        end
    end

endmodule

// File: tb/tb_key_event_classifier.sv
// Bench for key_event_classifier: directed gesture table, reset sequence, random model check.
module tb_key_event_classifier;
    import key_evt_pkg::*;

    localparam int unsigned LC = 20;
    localparam int unsigned DC = 10;
    localparam int unsigned RC = 5;

    logic clk = 1'b0;
    logic rst;
    logic in_press_pulse, in_release_pulse;
    logic out_short_press, out_double_click, out_long_press, out_repeat, out_key_held;
    logic [4:0] dut_out;

    int vectors = 0;
    int miscompares = 0;
    logic [4:0] exp_q[$];

    // Reference model state
    logic [2:0] m_state;
    int         m_age;

    always #5 clk = ~clk;

    assign dut_out = {out_key_held, out_repeat, out_long_press, out_double_click, out_short_press};

    key_event_classifier #(
        .LONG_CYC   (LC),
        .DBL_CYC    (DC),
        .REPEAT_CYC (RC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_press_pulse   (in_press_pulse),
        .in_release_pulse (in_release_pulse),
        .out_short_press  (out_short_press),
        .out_double_click (out_double_click),
        .out_long_press   (out_long_press),
        .out_repeat       (out_repeat),
        .out_key_held     (out_key_held)
    );

    // Stimulus edges and expected pulse edges; -1 means none.
    typedef struct {
        string name;
        int p0, r0, p1, r1, b, ncyc;
        int e_short, e_dbl, e_long, e_rep0, e_rep1;
        int h0on, h0off, h1on, h1off;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [4:0] got, input logic [4:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got {held,rpt,long,dbl,short}=%b expected %b at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic p, input logic r, input logic [4:0] e, input string nm);
        logic [4:0] want;
        in_press_pulse   = p;
        in_release_pulse = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check(nm, dut_out, want);
    endtask

    function automatic logic [4:0] expected_at(input vec_t v, input int t);
        logic [4:0] e;
        e[0] = (t == v.e_short);
        e[1] = (t == v.e_dbl);
        e[2] = (t == v.e_long);
        e[3] = (t == v.e_rep0) || (t == v.e_rep1);
        e[4] = (t >= v.h0on && t < v.h0off) || (t >= v.h1on && t < v.h1off);
        return e;
    endfunction

    task automatic model_step(input logic p, input logic r, output logic [4:0] e);
        logic       pv, rv, again;
        logic [2:0] nxt;
        pv    = p && !r;
        rv    = r && !p;
        nxt   = m_state;
        again = 1'b0;
        e     = '0;
        if (m_state == IDLE) begin
            if (pv) nxt = PRESS1;
        end else if (m_state == PRESS1) begin
            if (rv) nxt = WAIT2;
            else if (m_age == int'(LC) - 1) begin nxt = LONG_HOLD; e[2] = 1'b1; end
        end else if (m_state == WAIT2) begin
            if (pv) nxt = PRESS2;
            else if (m_age == int'(DC) - 1) begin nxt = IDLE; e[0] = 1'b1; end
        end else if (m_state == PRESS2) begin
            if (rv) begin nxt = IDLE; e[1] = 1'b1; end
        end else begin
            if (rv) nxt = IDLE;
            else if (m_age == int'(RC) - 1) begin e[3] = 1'b1; again = 1'b1; end
        end
        if (nxt != m_state || again) m_age = 0;
        else m_age = m_age + 1;
        m_state = nxt;
        e[4] = (m_state == PRESS1) || (m_state == PRESS2) || (m_state == LONG_HOLD);
    endtask

    initial begin
        logic [4:0] e;
        logic       p, r, key_down;
        int         gap;

        vecs[0] = '{"short",       0,  5, -1, -1, -1, 22, 15, -1, -1, -1, -1, 0,  5, -1, -1};
        vecs[1] = '{"double",      0,  5,  9, 12, -1, 30, -1, 12, -1, -1, -1, 0,  5,  9, 12};
        vecs[2] = '{"long_rep",    0, 32, -1, -1, -1, 45, -1, -1, 20, 25, 30, 0, 32, -1, -1};
        vecs[3] = '{"long_edge",   0, 20, -1, -1, -1, 35, 30, -1, -1, -1, -1, 0, 20, -1, -1};
        vecs[4] = '{"dbl_edge",    0,  5, 15, 17, -1, 30, -1, 17, -1, -1, -1, 0,  5, 15, 17};
        vecs[5] = '{"both_idle",  -1, -1, -1, -1,  0,  5, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        vecs[6] = '{"dup_press",   0,  6,  3, -1, -1, 20, 16, -1, -1, -1, -1, 0,  6, -1, -1};
        vecs[7] = '{"both_press1", 0,  6, -1, -1,  3, 20, 16, -1, -1, -1, -1, 0,  6, -1, -1};
        vecs[8] = '{"rep_edge",    0, 25, -1, -1, -1, 32, -1, -1, 20, -1, -1, 0, 25, -1, -1};

        rst              = 1'b1;
        in_press_pulse   = 1'b0;
        in_release_pulse = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_out, 5'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            for (int t = 0; t < vecs[i].ncyc; t++) begin
                p = (t == vecs[i].p0) || (t == vecs[i].p1) || (t == vecs[i].b);
                r = (t == vecs[i].r0) || (t == vecs[i].r1) || (t == vecs[i].b);
                cycle(p, r, expected_at(vecs[i], t), vecs[i].name);
            end
        end

        // Reset in the middle of a press: gesture discarded, later release ignored.
        for (int t = 0; t < 25; t++) begin
            if (t == 8) begin
                rst = 1'b1;
                #1;
                check("rst_async", dut_out, 5'b0);
            end
            if (t == 10) rst = 1'b0;
            cycle(t == 0, t == 12, (t < 8) ? 5'b10000 : 5'b00000, "rst_mid");
        end

        // Random legal pulse streams against the reference model.
        m_state  = IDLE;
        m_age    = 0;
        key_down = 1'b0;
        gap      = 3;
        for (int t = 0; t < 3000; t++) begin
            p = 1'b0;
            r = 1'b0;
            if (gap == 0) begin
                if ($urandom_range(0, 15) == 0) begin
                    p = 1'b1;
                    r = 1'b1;
                end else begin
                    p        = !key_down;
                    r        = key_down;
                    key_down = !key_down;
                end
                gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40))
                                                   : int'($urandom_range(1, 12));
            end else begin
                gap--;
            end
            model_step(p, r, e);
            cycle(p, r, e, "random");
            vectors++;
            if ($countones(dut_out[3:0]) > 1) begin
                miscompares++;
                $display("FAIL one_pulse: got pulses %b expected at most one high", dut_out[3:0]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
